// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the RV32I integer ALU and the control decoder that
// drives it: the datapath width and the 4-bit ALU operation encoding.
package alu_pkg;

    // Datapath width of the core.
    localparam int XLEN = 32;

    // Operation select driven onto ALUControl. Codes 1010-1110 are branch
    // conditions; they also produce A-B so a BEQ decision can use zero.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_BNE  = 4'b1010,
        ALU_BLT  = 4'b1011,
        ALU_BGE  = 4'b1100,
        ALU_BLTU = 4'b1101,
        ALU_BGEU = 4'b1110,
        ALU_RSVD = 4'b1111
    } aluOp_t;

endpackage

// File: rtl/alu_cmp.sv
// alu_cmp
// Operand comparator shared by SLT/SLTU and the branch-condition ops.
// Ports:
//   a, b        in   operands (two's complement or unsigned, both views given)
//   ltSigned    out  1 when a < b as signed values
//   ltUnsigned  out  1 when a < b as unsigned values
//   equal       out  1 when a == b
module alu_cmp
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ltSigned,
    output logic            ltUnsigned,
    output logic            equal
);

    // Purely combinational compares; the signed view reinterprets the same
    // bits so one operand pair serves both the signed and unsigned branches.
    always_comb begin
        ltSigned   = $signed(a) < $signed(b);
        ltUnsigned = a < b;
        equal      = (a == b);
    end

endmodule

// File: rtl/alu.sv
// alu
// Combinational 32-bit RV32I integer ALU with a registered copy of its outputs
// for pipelined or debug consumers.
// Ports:
//   clk           in   clocks only the registered output copies
//   rst_n         in   synchronous active-low reset of the registered copies
//   ALUControl    in   operation select (alu_pkg::aluOp_t encoding)
//   SrcA, SrcB    in   operands; SrcB low bits also give the shift amount
//   ALUResult     out  combinational result
//   zero          out  combinational, 1 when ALUResult is all zeros
//   comparison    out  combinational branch-condition flag
//   result_q      out  ALUResult registered on rising clk
//   zero_q        out  zero registered on rising clk
//   comparison_q  out  comparison registered on rising clk
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [XLEN-1:0] ALUResult,
    output logic            zero,
    output logic            comparison,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q,
    output logic            comparison_q
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    diff;
    logic               ltSigned;
    logic               ltUnsigned;
    logic               equal;

    alu_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .a         (SrcA),
        .b         (SrcB),
        .ltSigned  (ltSigned),
        .ltUnsigned(ltUnsigned),
        .equal     (equal)
    );

    // Upper SrcB bits are ignored for shifts; the difference is shared by SUB
    // and every branch op so zero doubles as the BEQ condition.
    assign shamt = SrcB[SHAMT_W-1:0];
    assign diff  = SrcA - SrcB;

    // Operation mux. Defaults first so any unlisted or X select falls back to
    // the reserved behaviour (result 0, no branch) rather than holding state.
    always_comb begin
        ALUResult  = '0;
        comparison = 1'b0;
        case (ALUControl)
            ALU_ADD:  ALUResult = SrcA + SrcB;
            ALU_SUB:  ALUResult = diff;
            ALU_AND:  ALUResult = SrcA & SrcB;
            ALU_OR:   ALUResult = SrcA | SrcB;
            ALU_XOR:  ALUResult = SrcA ^ SrcB;
            ALU_SLT:  ALUResult = {{(XLEN-1){1'b0}}, ltSigned};
            ALU_SLTU: ALUResult = {{(XLEN-1){1'b0}}, ltUnsigned};
            ALU_SLL:  ALUResult = SrcA << shamt;
            ALU_SRL:  ALUResult = SrcA >> shamt;
            ALU_SRA:  ALUResult = $unsigned($signed(SrcA) >>> shamt);
            ALU_BNE: begin
                ALUResult  = diff;
                comparison = !equal;
            end
            ALU_BLT: begin
                ALUResult  = diff;
                comparison = ltSigned;
            end
            ALU_BGE: begin
                ALUResult  = diff;
                comparison = !ltSigned;
            end
            ALU_BLTU: begin
                ALUResult  = diff;
                comparison = ltUnsigned;
            end
            ALU_BGEU: begin
                ALUResult  = diff;
                comparison = !ltUnsigned;
            end
            default: begin
                ALUResult  = '0;
                comparison = 1'b0;
            end
        endcase
    end

    assign zero = (ALUResult == '0);

    // Registered copies of the combinational outputs. Reset clears only these;
    // the combinational path never sees rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q     <= '0;
            zero_q       <= 1'b0;
            comparison_q <= 1'b0;
        end else begin
            result_q     <= ALUResult;
            zero_q       <= zero;
            comparison_q <= comparison;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu
// Directed-vector bench for alu: combinational result/zero/comparison for
// every op class, then the registered copies across reset and load.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] ALUResult;
    logic        zero;
    logic        comparison;
    logic [31:0] result_q;
    logic        zero_q;
    logic        comparison_q;

    int checks   = 0;
    int failures = 0;

    alu #(
        .XLEN(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ALUControl  (ALUControl),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .ALUResult   (ALUResult),
        .zero        (zero),
        .comparison  (comparison),
        .result_q    (result_q),
        .zero_q      (zero_q),
        .comparison_q(comparison_q)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive operands and let the combinational path settle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        #1;
    endtask

    // Apply one vector and check all three combinational outputs.
    task automatic runVector(input string tag, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expResult, input logic expZero,
                             input logic expCmp);
        applyStimulus(op, a, b);
        checkOutput({tag, ".res"},  ALUResult, expResult);
        checkOutput({tag, ".zero"}, {31'b0, zero}, {31'b0, expZero});
        checkOutput({tag, ".cmp"},  {31'b0, comparison}, {31'b0, expCmp});
    endtask

    // Check the three registered outputs together.
    task automatic checkRegs(input string tag, input logic [31:0] expResult,
                             input logic expZero, input logic expCmp);
        checkOutput({tag, ".result_q"},     result_q, expResult);
        checkOutput({tag, ".zero_q"},       {31'b0, zero_q}, {31'b0, expZero});
        checkOutput({tag, ".comparison_q"}, {31'b0, comparison_q}, {31'b0, expCmp});
    endtask

    initial begin
        rst_n      = 1'b0;
        ALUControl = ALU_ADD;
        SrcA       = '0;
        SrcB       = '0;

        // Arithmetic, including wrap.
        runVector("add",      ALU_ADD,  32'd10, 32'd5, 32'd15, 1'b0, 1'b0);
        runVector("sub",      ALU_SUB,  32'd10, 32'd5, 32'd5,  1'b0, 1'b0);
        runVector("sub_eq",   ALU_SUB,  32'd5,  32'd5, 32'd0,  1'b1, 1'b0);
        runVector("add_wrap", ALU_ADD,  32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0);
        runVector("sub_neg",  ALU_SUB,  32'd0,  32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Logic.
        runVector("and11", ALU_AND, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
        runVector("and01", ALU_AND, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0);
        runVector("or01",  ALU_OR,  32'd0, 32'd1, 32'd1, 1'b0, 1'b0);
        runVector("or00",  ALU_OR,  32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        runVector("xor01", ALU_XOR, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0);
        runVector("xor00", ALU_XOR, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        runVector("xorpat", ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);

        // Set-less-than.
        runVector("slt_1_7",   ALU_SLT,  32'd1, 32'd7, 32'd1, 1'b0, 1'b0);
        runVector("slt_m1_1",  ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        runVector("slt_1_m1",  ALU_SLT,  32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
        runVector("sltu_2_1",  ALU_SLTU, 32'd2, 32'd1, 32'd0, 1'b1, 1'b0);
        runVector("sltu_ff_1", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        runVector("sltu_1_ff", ALU_SLTU, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);

        // Shifts, including ignored upper SrcB bits and zero shift amount.
        runVector("sll",      ALU_SLL, 32'd1, 32'd2, 32'd4, 1'b0, 1'b0);
        runVector("sll31",    ALU_SLL, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0);
        runVector("srl",      ALU_SRL, 32'd8, 32'd2, 32'd2, 1'b0, 1'b0);
        runVector("sra",      ALU_SRA, 32'd8, 32'd2, 32'd2, 1'b0, 1'b0);
        runVector("sra_neg",  ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0);
        runVector("srl_mask", ALU_SRL, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1'b0);
        runVector("sra_sh0",  ALU_SRA, 32'h80000000, 32'h20, 32'h80000000, 1'b0, 1'b0);

        // Branch conditions; result is A-B.
        runVector("bne_eq",    ALU_BNE,  32'd1, 32'd1, 32'd0, 1'b1, 1'b0);
        runVector("bne_ne",    ALU_BNE,  32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b1);
        runVector("blt_0_1",   ALU_BLT,  32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b1);
        runVector("blt_2_1",   ALU_BLT,  32'd2, 32'd1, 32'd1, 1'b0, 1'b0);
        runVector("blt_m1_1",  ALU_BLT,  32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b0, 1'b1);
        runVector("bge_2_1",   ALU_BGE,  32'd2, 32'd1, 32'd1, 1'b0, 1'b1);
        runVector("bge_0_1",   ALU_BGE,  32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
        runVector("bge_eq",    ALU_BGE,  32'd3, 32'd3, 32'd0, 1'b1, 1'b1);
        runVector("bltu_1_ff", ALU_BLTU, 32'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
        runVector("bgeu_1_ff", ALU_BGEU, 32'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        runVector("bgeu_eq",   ALU_BGEU, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);

        // Reserved op.
        runVector("rsvd", ALU_RSVD, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);

        // Registered copies: reset held for two edges with a non-zero value present.
        applyStimulus(ALU_BNE, 32'd0, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkRegs("rst_hold", 32'd0, 1'b0, 1'b0);

        // Release reset and load ADD 10+5.
        rst_n = 1'b1;
        applyStimulus(ALU_ADD, 32'd10, 32'd5);
        @(posedge clk);
        #1;
        checkRegs("load_add", 32'd15, 1'b0, 1'b0);

        // Load a taken branch so comparison_q goes high.
        applyStimulus(ALU_BNE, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        checkRegs("load_bne", 32'hFFFFFFFF, 1'b0, 1'b1);

        // Load a zero result so zero_q goes high.
        applyStimulus(ALU_SUB, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        checkRegs("load_zero", 32'd0, 1'b1, 1'b0);

        // Mid-run reset clears registers while the combinational output holds.
        applyStimulus(ALU_ADD, 32'd10, 32'd5);
        @(posedge clk);
        #1;
        checkRegs("pre_rst", 32'd15, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkRegs("mid_rst", 32'd0, 1'b0, 1'b0);
        checkOutput("mid_rst.ALUResult", ALUResult, 32'd15);
        checkOutput("mid_rst.zero", {31'b0, zero}, 32'd0);

        // Next edge out of reset reloads the current value.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkRegs("post_rst", 32'd15, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
